wb_commit_queue: RTL and testbench

Parametrised writeback/commit stage that sits between the MEM stage and the register file and CSR unit. It replaces the single-register WB stage with a DEPTH-entry in-order commit queue. It commits one entry per cycle unless stalled, prioritises and encodes exceptions, writes BADV, and flushes all younger entries on exception or ertn. It also provides multi-entry forwarding lookup and a system-op-pending indication to ID.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/wb_commit_queue_excp_encode.sv | 42 ++++
 rtl/wb_commit_queue.sv | 172 +++++++++++++++++
 tb/tb_wb_commit_queue.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: exception codes, CSR numbers and the writeback entry layout.
// The struct field widths are fixed here; the commit-queue width parameters default to the same values.
package cpu_pkg;

  localparam int unsigned WB_DATA_W    = 32;
  localparam int unsigned WB_DEST_W    = 5;
  localparam int unsigned WB_CSR_NUM_W = 14;
  localparam int unsigned WB_NEXCP     = 6;

  localparam logic [5:0] ECODE_INT       = 6'h00;
  localparam logic [5:0] ECODE_ADEF_ADEM = 6'h08;
  localparam logic [5:0] ECODE_ALE       = 6'h09;
  localparam logic [5:0] ECODE_SYS       = 6'h0b;
  localparam logic [5:0] ECODE_BRK       = 6'h0c;
  localparam logic [5:0] ECODE_INE       = 6'h0d;
  localparam logic [8:0] ESUBCODE_ADEF   = 9'h000;

  localparam logic [WB_CSR_NUM_W-1:0] CSR_BADV = 14'h0007;

  // Exception vector bit positions; lower index has higher priority.
  localparam int unsigned EXC_INT  = 0;
  localparam int unsigned EXC_ADEF = 1;
  localparam int unsigned EXC_BRK  = 2;
  localparam int unsigned EXC_SYS  = 3;
  localparam int unsigned EXC_INE  = 4;
  localparam int unsigned EXC_ALE  = 5;

  typedef struct packed {
    logic [31:0]             pc;
    logic                    gr_we;
    logic [WB_DEST_W-1:0]    dest;
    logic [WB_DATA_W-1:0]    result;
    logic                    ertn;
    logic                    csr_we;
    logic [WB_CSR_NUM_W-1:0] csr_num;
    logic [WB_DATA_W-1:0]    csr_wvalue;
    logic [WB_NEXCP-1:0]     excp_vec;
  } wb_entry_t;

endpackage

// File: rtl/wb_commit_queue_excp_encode.sv
// Fixed-priority exception encoder for the committing entry; also selects BADV write data.
module wb_excp_encode
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned NEXCP  = WB_NEXCP
) (
  input  logic [NEXCP-1:0]  vec,
  input  logic [31:0]       pc,
  input  logic [DATA_W-1:0] result,
  output logic [5:0]        ecode,
  output logic [8:0]        esubcode,
  output logic              badv_we,
  output logic [DATA_W-1:0] badv_data
);

  always_comb begin
    ecode     = '0;
    esubcode  = '0;
    badv_we   = 1'b0;
    badv_data = '0;
    if (vec[EXC_INT]) begin
      ecode = ECODE_INT;
    end else if (vec[EXC_ADEF]) begin
      ecode     = ECODE_ADEF_ADEM;
      esubcode  = ESUBCODE_ADEF;
      badv_we   = 1'b1;
      badv_data = DATA_W'(pc);
    end else if (vec[EXC_BRK]) begin
      ecode = ECODE_BRK;
    end else if (vec[EXC_SYS]) begin
      ecode = ECODE_SYS;
    end else if (vec[EXC_INE]) begin
      ecode = ECODE_INE;
    end else if (vec[EXC_ALE]) begin
      ecode     = ECODE_ALE;
      badv_we   = 1'b1;
      badv_data = result;
    end
  end

endmodule

// File: rtl/wb_commit_queue.sv
// In-order writeback commit queue: commits one head entry per cycle, raises exception/ertn
// flushes that drop all younger entries, and offers youngest-match forwarding to ID.
module wb_commit_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W    = WB_DATA_W,
  parameter int unsigned DEST_W    = WB_DEST_W,
  parameter int unsigned CSR_NUM_W = WB_CSR_NUM_W,
  parameter int unsigned NEXCP     = WB_NEXCP,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 me_valid,
  output logic                 me_ready,
  input  logic [31:0]          me_pc,
  input  logic                 me_gr_we,
  input  logic [DEST_W-1:0]    me_dest,
  input  logic [DATA_W-1:0]    me_result,
  input  logic                 me_ertn,
  input  logic                 me_csr_we,
  input  logic [CSR_NUM_W-1:0] me_csr_num,
  input  logic [DATA_W-1:0]    me_csr_wvalue,
  input  logic [NEXCP-1:0]     me_excp_vec,
  input  logic                 commit_stall,
  input  logic [DEST_W-1:0]    fwd_raddr1,
  input  logic [DEST_W-1:0]    fwd_raddr2,
  output logic                 fwd_hit1,
  output logic                 fwd_hit2,
  output logic [DATA_W-1:0]    fwd_data1,
  output logic [DATA_W-1:0]    fwd_data2,
  output logic                 sys_op_pending,
  output logic                 rf_we,
  output logic [DEST_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_we,
  output logic [DEST_W-1:0]    debug_wb_rf_wnum,
  output logic [DATA_W-1:0]    debug_wb_rf_wdata,
  output logic                 csr_we,
  output logic [CSR_NUM_W-1:0] csr_num,
  output logic [DATA_W-1:0]    csr_wvalue,
  output logic                 excp_flush,
  output logic                 ertn_flush,
  output logic [5:0]           wb_ecode,
  output logic [8:0]           wb_esubcode,
  output logic [CNT_W-1:0]     occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_entry_t           q [DEPTH];
  wb_entry_t           in_entry;
  wb_entry_t           head;
  logic [DEPTH-1:0]    vld;
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    count;
  logic                head_valid, excp_en, commit_fire, flush_now, enq;
  logic [5:0]          ecode;
  logic [8:0]          esubcode;
  logic                badv_we;
  logic [DATA_W-1:0]   badv_data;

  always_comb begin
    in_entry            = '0;
    in_entry.pc         = me_pc;
    in_entry.gr_we      = me_gr_we;
    in_entry.dest       = me_dest;
    in_entry.result     = me_result;
    in_entry.ertn       = me_ertn;
    in_entry.csr_we     = me_csr_we;
    in_entry.csr_num    = me_csr_num;
    in_entry.csr_wvalue = me_csr_wvalue;
    in_entry.excp_vec   = me_excp_vec;
  end

  assign head        = q[rd_ptr];
  assign head_valid  = vld[rd_ptr];
  assign excp_en     = |head.excp_vec;
  assign commit_fire = head_valid && !commit_stall;
  assign flush_now   = commit_fire && (excp_en || head.ertn);
  assign me_ready    = (count < CNT_W'(DEPTH) || commit_fire) && !flush_now;
  assign enq         = me_valid && me_ready;

  // Payload is not reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (enq) q[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else if (flush_now) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      // Enqueue is applied last so a full-queue commit+enqueue on the same slot stays valid.
      if (commit_fire) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PTR_W'(1);
      end
      if (enq) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(enq) - CNT_W'(commit_fire);
    end
  end

  wb_excp_encode #(
    .DATA_W (DATA_W),
    .NEXCP  (NEXCP)
  ) u_excp_encode (
    .vec       (head.excp_vec),
    .pc        (head.pc),
    .result    (head.result),
    .ecode     (ecode),
    .esubcode  (esubcode),
    .badv_we   (badv_we),
    .badv_data (badv_data)
  );

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx            = '0;
    fwd_hit1       = 1'b0;
    fwd_hit2       = 1'b0;
    fwd_data1      = '0;
    fwd_data2      = '0;
    sys_op_pending = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (vld[idx] && (|q[idx].excp_vec || q[idx].ertn)) sys_op_pending = 1'b1;
      if (vld[idx] && q[idx].gr_we && !(|q[idx].excp_vec)) begin
        if (fwd_raddr1 != '0 && q[idx].dest == fwd_raddr1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = q[idx].result;
        end
        if (fwd_raddr2 != '0 && q[idx].dest == fwd_raddr2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = q[idx].result;
        end
      end
    end
  end

  assign rf_we             = commit_fire && head.gr_we && !excp_en;
  assign rf_waddr          = commit_fire ? head.dest : '0;
  assign rf_wdata          = commit_fire ? head.result : '0;
  assign debug_wb_pc       = commit_fire ? head.pc : '0;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  assign csr_we     = commit_fire && ((head.csr_we && !excp_en) || badv_we);
  assign csr_num    = !commit_fire ? '0 : (badv_we ? CSR_BADV : head.csr_num);
  assign csr_wvalue = !commit_fire ? '0 : (badv_we ? badv_data : head.csr_wvalue);

  assign excp_flush  = flush_now && excp_en;
  assign ertn_flush  = flush_now && head.ertn && !excp_en;
  assign wb_ecode    = (commit_fire && excp_en) ? ecode : '0;
  assign wb_esubcode = (commit_fire && excp_en) ? esubcode : '0;
  assign occupancy   = count;

endmodule

// File: tb/tb_wb_commit_queue.sv
// Scenario bench for wb_commit_queue: commits are checked against a scoreboard of expected entries.
module tb_wb_commit_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        me_valid, me_ready;
  logic [31:0] me_pc;
  logic        me_gr_we;
  logic [4:0]  me_dest;
  logic [31:0] me_result;
  logic        me_ertn, me_csr_we;
  logic [13:0] me_csr_num;
  logic [31:0] me_csr_wvalue;
  logic [5:0]  me_excp_vec;
  logic        commit_stall;
  logic [4:0]  fwd_raddr1, fwd_raddr2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic        sys_op_pending, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wvalue;
  logic        excp_flush, ertn_flush;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [1:0]  occupancy;

  always #5 clk = ~clk;

  wb_commit_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .me_valid(me_valid), .me_ready(me_ready), .me_pc(me_pc),
    .me_gr_we(me_gr_we), .me_dest(me_dest), .me_result(me_result), .me_ertn(me_ertn),
    .me_csr_we(me_csr_we), .me_csr_num(me_csr_num), .me_csr_wvalue(me_csr_wvalue),
    .me_excp_vec(me_excp_vec), .commit_stall(commit_stall), .fwd_raddr1(fwd_raddr1),
    .fwd_raddr2(fwd_raddr2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1),
    .fwd_data2(fwd_data2), .sys_op_pending(sys_op_pending), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .csr_we(csr_we), .csr_num(csr_num), .csr_wvalue(csr_wvalue), .excp_flush(excp_flush),
    .ertn_flush(ertn_flush), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .occupancy(occupancy)
  );

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Every commit (non-zero debug PC) must match the oldest expected entry.
  always @(negedge clk) begin
    if (resetn === 1'b1 && debug_wb_pc !== 32'h0) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected got pc=%h we=%b, no commit expected", debug_wb_pc, rf_we);
      end else begin
        e = sb.pop_front();
        if (debug_wb_pc !== e.pc || rf_we !== e.we || debug_wb_rf_we !== {4{e.we}} ||
            (e.we && (rf_waddr !== e.dest || rf_wdata !== e.data ||
                      debug_wb_rf_wnum !== e.dest || debug_wb_rf_wdata !== e.data))) begin
          errors++;
          $display("FAIL commit_entry got pc=%h we=%b waddr=%0d wdata=%h expected pc=%h we=%b waddr=%0d wdata=%h",
                   debug_wb_pc, rf_we, rf_waddr, rf_wdata, e.pc, e.we, e.dest, e.data);
        end
      end
    end
  end

  task cyc;
    @(posedge clk);
    #1;
  endtask

  task idle;
    me_valid = 0; me_pc = '0; me_gr_we = 0; me_dest = '0; me_result = '0; me_ertn = 0;
    me_csr_we = 0; me_csr_num = '0; me_csr_wvalue = '0; me_excp_vec = '0;
  endtask

  task offer(input logic [31:0] pc, input logic we, input logic [4:0] dest, input logic [31:0] res,
             input logic ertn, input logic cwe, input logic [13:0] cnum, input logic [31:0] cval,
             input logic [5:0] vec);
    me_valid = 1; me_pc = pc; me_gr_we = we; me_dest = dest; me_result = res; me_ertn = ertn;
    me_csr_we = cwe; me_csr_num = cnum; me_csr_wvalue = cval; me_excp_vec = vec;
  endtask

  task test_reset;
    resetn = 0; idle(); commit_stall = 0; fwd_raddr1 = '0; fwd_raddr2 = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    #2;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (me_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", me_ready); end
    checks++; if ({rf_we, csr_we, excp_flush, ertn_flush, sys_op_pending} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000", {rf_we, csr_we, excp_flush, ertn_flush, sys_op_pending}); end
    checks++; if (debug_wb_pc !== 32'h0 || wb_ecode !== 6'h0) begin
      errors++; $display("FAIL reset_data got pc=%h ecode=%h exp 0", debug_wb_pc, wb_ecode); end
  endtask

  task test_basic;
    cyc(); offer(32'h1c000000, 1, 5'd5, 32'h1234, 0, 0, '0, '0, '0); #2;
    checks++; if (me_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b exp=1", me_ready); end
    sb.push_back('{32'h1c000000, 1'b1, 5'd5, 32'h1234});
    cyc(); idle(); fwd_raddr1 = 5'd5; #2;
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL basic_occ1 got=%0d exp=1", occupancy); end
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
      errors++; $display("FAIL basic_commit got we=%b a=%0d d=%h exp 1/5/1234", rf_we, rf_waddr, rf_wdata); end
    checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h1234) begin
      errors++; $display("FAIL basic_fwd got hit=%b d=%h exp 1/1234", fwd_hit1, fwd_data1); end
    cyc(); #2;
    checks++; if (occupancy !== 2'd0 || rf_we !== 1'b0 || fwd_hit1 !== 1'b0) begin
      errors++; $display("FAIL basic_drain got occ=%0d we=%b hit=%b exp 0/0/0", occupancy, rf_we, fwd_hit1); end
  endtask

  task test_stall;
    cyc(); commit_stall = 1; offer(32'h1c000010, 1, 5'd5, 32'h11, 0, 0, '0, '0, '0); #2;
    checks++; if (me_ready !== 1'b1) begin errors++; $display("FAIL stall_rdyA got=%b exp=1", me_ready); end
    sb.push_back('{32'h1c000010, 1'b1, 5'd5, 32'h11});
    cyc(); offer(32'h1c000014, 1, 5'd5, 32'h22, 0, 0, '0, '0, '0); #2;
    checks++; if (me_ready !== 1'b1 || occupancy !== 2'd1 || rf_we !== 1'b0) begin
      errors++; $display("FAIL stall_B got rdy=%b occ=%0d we=%b exp 1/1/0", me_ready, occupancy, rf_we); end
    sb.push_back('{32'h1c000014, 1'b1, 5'd5, 32'h22});
    cyc(); offer(32'h1c000018, 1, 5'd6, 32'h33, 0, 0, '0, '0, '0); fwd_raddr1 = 5'd5; fwd_raddr2 = 5'd6; #2;
    checks++; if (me_ready !== 1'b0 || occupancy !== 2'd2) begin
      errors++; $display("FAIL stall_full got rdy=%b occ=%0d exp 0/2", me_ready, occupancy); end
    checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22 || fwd_hit2 !== 1'b0) begin
      errors++; $display("FAIL stall_fwd got hit1=%b d1=%h hit2=%b exp 1/22/0", fwd_hit1, fwd_data1, fwd_hit2); end
    cyc(); commit_stall = 0; #2;
    checks++; if (me_ready !== 1'b1 || rf_wdata !== 32'h11 || occupancy !== 2'd2) begin
      errors++; $display("FAIL stall_full_enq got rdy=%b d=%h occ=%0d exp 1/11/2", me_ready, rf_wdata, occupancy); end
    sb.push_back('{32'h1c000018, 1'b1, 5'd6, 32'h33});
    cyc(); idle(); fwd_raddr2 = 5'd0; #2;
    checks++; if (rf_wdata !== 32'h22 || occupancy !== 2'd2 || fwd_hit2 !== 1'b0) begin
      errors++; $display("FAIL stall_c2 got d=%h occ=%0d hit2=%b exp 22/2/0", rf_wdata, occupancy, fwd_hit2); end
    cyc(); #2;
    checks++; if (rf_wdata !== 32'h33 || rf_waddr !== 5'd6 || occupancy !== 2'd1) begin
      errors++; $display("FAIL stall_c3 got d=%h a=%0d occ=%0d exp 33/6/1", rf_wdata, rf_waddr, occupancy); end
    cyc(); #2;
    checks++; if (occupancy !== 2'd0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL stall_drain got occ=%0d we=%b exp 0/0", occupancy, rf_we); end
  endtask

  task test_ale;
    cyc(); commit_stall = 1; offer(32'h1c000020, 1, 5'd7, 32'h1003, 0, 0, '0, '0, 6'b100000); #2;
    sb.push_back('{32'h1c000020, 1'b0, 5'd0, 32'h0});
    cyc(); offer(32'h1c000024, 1, 5'd8, 32'h55, 0, 0, '0, '0, '0); fwd_raddr1 = 5'd7; #2;
    checks++; if (me_ready !== 1'b1 || sys_op_pending !== 1'b1 || fwd_hit1 !== 1'b0) begin
      errors++; $display("FAIL ale_queue got rdy=%b sys=%b hit=%b exp 1/1/0", me_ready, sys_op_pending, fwd_hit1); end
    cyc(); commit_stall = 0; offer(32'h1c000028, 1, 5'd9, 32'h66, 0, 0, '0, '0, '0); #2;
    checks++; if (excp_flush !== 1'b1 || ertn_flush !== 1'b0 || wb_ecode !== 6'h09 || rf_we !== 1'b0 || me_ready !== 1'b0) begin
      errors++; $display("FAIL ale_flush got ex=%b er=%b ecode=%h we=%b rdy=%b exp 1/0/09/0/0",
                         excp_flush, ertn_flush, wb_ecode, rf_we, me_ready); end
    checks++; if (csr_we !== 1'b1 || csr_num !== 14'h7 || csr_wvalue !== 32'h1003) begin
      errors++; $display("FAIL ale_badv got we=%b num=%h val=%h exp 1/7/1003", csr_we, csr_num, csr_wvalue); end
    cyc(); idle(); #2;
    checks++; if (occupancy !== 2'd0 || excp_flush !== 1'b0 || sys_op_pending !== 1'b0) begin
      errors++; $display("FAIL ale_after got occ=%0d ex=%b sys=%b exp 0/0/0", occupancy, excp_flush, sys_op_pending); end
    repeat (2) cyc();
  endtask

  task test_excp_priority;
    logic [5:0]  tv_vec  [4];
    logic [5:0]  tv_code [4];
    logic        tv_badv [4];
    logic [31:0] pc;
    tv_vec  = '{6'b000110, 6'b011000, 6'b110000, 6'b100001};
    tv_code = '{6'h08, 6'h0b, 6'h0d, 6'h00};
    tv_badv = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      pc = 32'h1c000004 + 32'(i * 16);
      cyc(); offer(pc, 1, 5'd3, 32'hdead0000 + 32'(i), 0, 1, 14'h5, 32'h77, tv_vec[i]);
      sb.push_back('{pc, 1'b0, 5'd0, 32'h0});
      cyc(); idle(); #2;
      checks++; if (excp_flush !== 1'b1 || wb_ecode !== tv_code[i] || wb_esubcode !== 9'h0 || rf_we !== 1'b0) begin
        errors++; $display("FAIL prio_code[%0d] got ex=%b ecode=%h esub=%h we=%b exp 1/%h/0/0",
                           i, excp_flush, wb_ecode, wb_esubcode, rf_we, tv_code[i]); end
      checks++; if (csr_we !== tv_badv[i] || (tv_badv[i] && (csr_num !== 14'h7 || csr_wvalue !== pc))) begin
        errors++; $display("FAIL prio_csr[%0d] got we=%b num=%h val=%h exp we=%b val=%h",
                           i, csr_we, csr_num, csr_wvalue, tv_badv[i], pc); end
    end
  endtask

  task test_csr;
    cyc(); offer(32'h1c000040, 0, 5'd0, 32'h0, 0, 1, 14'h30, 32'habcd, '0);
    sb.push_back('{32'h1c000040, 1'b0, 5'd0, 32'h0});
    cyc(); idle(); #2;
    checks++; if (csr_we !== 1'b1 || csr_num !== 14'h30 || csr_wvalue !== 32'habcd || excp_flush !== 1'b0) begin
      errors++; $display("FAIL csr_write got we=%b num=%h val=%h ex=%b exp 1/30/abcd/0", csr_we, csr_num, csr_wvalue, excp_flush); end
  endtask

  task test_ertn;
    cyc(); commit_stall = 1; offer(32'h1c000050, 0, 5'd0, 32'h0, 1, 0, '0, '0, '0);
    sb.push_back('{32'h1c000050, 1'b0, 5'd0, 32'h0});
    cyc(); offer(32'h1c000054, 1, 5'd4, 32'h44, 0, 0, '0, '0, '0); #2;
    checks++; if (sys_op_pending !== 1'b1 || ertn_flush !== 1'b0 || occupancy !== 2'd1) begin
      errors++; $display("FAIL ertn_pend got sys=%b er=%b occ=%0d exp 1/0/1", sys_op_pending, ertn_flush, occupancy); end
    cyc(); commit_stall = 0; offer(32'h1c000058, 1, 5'd4, 32'h77, 0, 0, '0, '0, '0); #2;
    checks++; if (ertn_flush !== 1'b1 || excp_flush !== 1'b0 || me_ready !== 1'b0 || csr_we !== 1'b0) begin
      errors++; $display("FAIL ertn_flush got er=%b ex=%b rdy=%b cwe=%b exp 1/0/0/0", ertn_flush, excp_flush, me_ready, csr_we); end
    cyc(); idle(); #2;
    checks++; if (ertn_flush !== 1'b0 || occupancy !== 2'd0 || sys_op_pending !== 1'b0) begin
      errors++; $display("FAIL ertn_after got er=%b occ=%0d sys=%b exp 0/0/0", ertn_flush, occupancy, sys_op_pending); end
  endtask

  task test_back_to_back;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      cyc(); offer(32'h1c000100 + 32'(i * 4), 1, 5'(i + 1), d, 0, 0, '0, '0, '0); #2;
      checks++; if (me_ready !== 1'b1 || (i > 0 && occupancy !== 2'd1)) begin
        errors++; $display("FAIL b2b[%0d] got rdy=%b occ=%0d exp 1/1", i, me_ready, occupancy); end
      sb.push_back('{32'h1c000100 + 32'(i * 4), 1'b1, 5'(i + 1), d});
    end
    cyc(); idle(); #2;
    cyc(); #2;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL b2b_drain got occ=%0d exp 0", occupancy); end
  endtask

  task test_async_reset;
    cyc(); commit_stall = 1; offer(32'h1c000200, 1, 5'd10, 32'haa, 0, 0, '0, '0, '0);
    cyc(); offer(32'h1c000204, 1, 5'd11, 32'hbb, 0, 0, '0, '0, '0);
    cyc(); idle(); #2;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL arst_full got occ=%0d exp 2", occupancy); end
    commit_stall = 0; resetn = 0; #1;
    checks++; if (occupancy !== 2'd0 || rf_we !== 1'b0 || me_ready !== 1'b1 || debug_wb_pc !== 32'h0) begin
      errors++; $display("FAIL arst_now got occ=%0d we=%b rdy=%b pc=%h exp 0/0/1/0", occupancy, rf_we, me_ready, debug_wb_pc); end
    cyc(); resetn = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(); #2;
      checks++; if (occupancy !== 2'd0 || debug_wb_pc !== 32'h0) begin
        errors++; $display("FAIL arst_idle[%0d] got occ=%0d pc=%h exp 0/0", i, occupancy, debug_wb_pc); end
    end
    cyc(); offer(32'h1c000300, 1, 5'd12, 32'hcc, 0, 0, '0, '0, '0);
    sb.push_back('{32'h1c000300, 1'b1, 5'd12, 32'hcc});
    cyc(); idle(); #2;
    checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'hcc) begin
      errors++; $display("FAIL arst_resume got we=%b d=%h exp 1/cc", rf_we, rf_wdata); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_ale();
    test_excp_priority();
    test_csr();
    test_ertn();
    test_back_to_back();
    test_async_reset();
    cyc(); cyc(); #2;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
